// File: rtl/trigger_encoder_pkg.sv
// trigger_encoder shared definitions: command codes,
// left-aligned serial patterns, lengths and FSM states.
package trigger_encoder_pkg;

   localparam logic [2:0] CMD_TRIG    = 3'd0;
   localparam logic [2:0] CMD_CAL     = 3'd1;
   localparam logic [2:0] CMD_RES_ROC = 3'd2;
   localparam logic [2:0] CMD_RES_TBM = 3'd3;
   localparam logic [2:0] CMD_SYNC    = 3'd4;
   localparam logic [2:0] CMD_TOKEN   = 3'd5;

   localparam logic [4:0] PAT_TRIG    = 5'b10000;
   localparam logic [4:0] PAT_CAL     = 5'b11000;
   localparam logic [4:0] PAT_RES_ROC = 5'b10100;
   localparam logic [4:0] PAT_RES_TBM = 5'b11100;
   localparam logic [4:0] PAT_SYNC    = 5'b10110;
   localparam logic [4:0] PAT_TOKEN   = 5'b11010;

   localparam logic [2:0] LEN_TRIG    = 3'd2;
   localparam logic [2:0] LEN_CAL     = 3'd3;
   localparam logic [2:0] LEN_RES_ROC = 3'd4;
   localparam logic [2:0] LEN_RES_TBM = 3'd4;
   localparam logic [2:0] LEN_SYNC    = 3'd5;
   localparam logic [2:0] LEN_TOKEN   = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_e;

   function automatic logic cmd_valid(
      input logic [2:0] c
   );
      return c <= CMD_TOKEN;
   endfunction

   function automatic logic [4:0] cmd_pat(
      input logic [2:0] c
   );
      case (c)
         CMD_TRIG:    return PAT_TRIG;
         CMD_CAL:     return PAT_CAL;
         CMD_RES_ROC: return PAT_RES_ROC;
         CMD_RES_TBM: return PAT_RES_TBM;
         CMD_SYNC:    return PAT_SYNC;
         CMD_TOKEN:   return PAT_TOKEN;
         default:     return 5'b00000;
      endcase
   endfunction

   function automatic logic [2:0] cmd_len(
      input logic [2:0] c
   );
      case (c)
         CMD_TRIG:    return LEN_TRIG;
         CMD_CAL:     return LEN_CAL;
         CMD_RES_ROC: return LEN_RES_ROC;
         CMD_RES_TBM: return LEN_RES_TBM;
         CMD_SYNC:    return LEN_SYNC;
         CMD_TOKEN:   return LEN_TOKEN;
         default:     return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/trigger_encoder_if.sv
// Command-in / serial-out bundle of the trigger encoder.
interface trigger_encoder_if;

   logic       sync;
   logic       trg_in;
   logic [2:0] data_in;
   logic       ser;
   logic       busy;
   logic       start;
   logic [7:0] drop_cnt;

   modport master (
      output sync, trg_in, data_in,
      input  ser, busy, start, drop_cnt
   );

   modport slave (
      input  sync, trg_in, data_in,
      output ser, busy, start, drop_cnt
   );

endinterface

// File: rtl/trigger_encoder_queue.sv
// Two-entry command FIFO; push and pop act only on sync
// cycles and may both happen on the same edge.
module trigger_encoder_queue (
   input  logic       clk,
   input  logic       reset,
   input  logic       sync,
   input  logic       push,
   input  logic       pop,
   input  logic [2:0] din,
   output logic       full,
   output logic       empty,
   output logic [2:0] head,
   output logic [1:0] level
);

   logic [2:0] e0_q, e0_d;
   logic [2:0] e1_q, e1_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] slot;
   logic       do_pop;
   logic       do_push;

   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);
   assign head  = e0_q;
   assign level = cnt_q;

   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      do_pop  = sync && pop && !empty;
      do_push = sync && push && (!full || do_pop);
      slot    = cnt_q - {1'b0, do_pop};
      if (do_pop)
         e0_d = e1_q;
      // new entry lands behind whatever survives the pop
      if (do_push) begin
         if (slot == 2'd0)
            e0_d = din;
         else
            e1_d = din;
      end
      cnt_d = cnt_q - {1'b0, do_pop} + {1'b0, do_push};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e0_q  <= 3'd0;
         e1_q  <= 3'd0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/trigger_encoder.sv
// Serialises trigger commands onto the ROC/TBM line, one
// pattern per command, stepping only on sync cycles.
module trigger_encoder
   import trigger_encoder_pkg::*;
#(
   parameter int unsigned GAP = 2
) (
   input  logic              clk,
   input  logic              reset,
   trigger_encoder_if.slave  bus
);

   localparam logic [3:0] GAP_W = 4'(GAP);

   state_e     state_q, state_d;
   logic [4:0] sr_q, sr_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] gap_q, gap_d;
   logic       ser_q, ser_d;
   logic       busy_q, busy_d;
   logic       start_q, start_d;
   logic [7:0] drop_q, drop_d;

   logic       q_push, q_pop, q_acc;
   logic       q_full, q_empty;
   logic [2:0] q_head;
   logic [1:0] q_level, lvl_nxt;
   logic       cmd_ok, cmd_bad;
   logic       idle_ev, ld_en;
   logic [2:0] ld_code;
   logic [4:0] ld_pat;

   trigger_encoder_queue u_queue (
      .clk   (clk),
      .reset (reset),
      .sync  (bus.sync),
      .push  (q_push),
      .pop   (q_pop),
      .din   (bus.data_in),
      .full  (q_full),
      .empty (q_empty),
      .head  (q_head),
      .level (q_level)
   );

   assign cmd_ok  = bus.trg_in && cmd_valid(bus.data_in);
   assign cmd_bad = bus.trg_in && !cmd_valid(bus.data_in);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      ser_d   = ser_q;
      busy_d  = busy_q;
      drop_d  = drop_q;
      start_d = 1'b0;
      q_pop   = 1'b0;
      q_push  = 1'b0;
      q_acc   = 1'b0;
      idle_ev = 1'b0;
      ld_en   = 1'b0;
      ld_code = bus.data_in;
      lvl_nxt = q_level;
      if (bus.sync) begin
         unique case (state_q)
            S_IDLE: idle_ev = 1'b1;
            S_SHIFT: begin
               if (bit_q != 3'd0) begin
                  ser_d = sr_q[4];
                  sr_d  = {sr_q[3:0], 1'b0};
                  bit_d = bit_q - 3'd1;
               end else if (GAP_W != 4'd0) begin
                  ser_d   = 1'b0;
                  state_d = S_GAP;
                  gap_d   = GAP_W;
               end else begin
                  idle_ev = 1'b1;
               end
            end
            S_GAP: begin
               if (gap_q > 4'd1)
                  gap_d = gap_q - 4'd1;
               else
                  idle_ev = 1'b1;
            end
            default: idle_ev = 1'b1;
         endcase
         // queued work always beats a fresh command
         if (idle_ev) begin
            if (!q_empty) begin
               q_pop   = 1'b1;
               ld_en   = 1'b1;
               ld_code = q_head;
            end else if (cmd_ok) begin
               ld_en = 1'b1;
            end else begin
               ser_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
      end
      ld_pat = cmd_pat(ld_code);
      if (ld_en) begin
         ser_d   = ld_pat[4];
         sr_d    = {ld_pat[3:0], 1'b0};
         bit_d   = cmd_len(ld_code) - 3'd1;
         state_d = S_SHIFT;
         start_d = 1'b1;
      end
      if (bus.sync) begin
         q_push  = cmd_ok && !(ld_en && !q_pop);
         q_acc   = q_push && (!q_full || q_pop);
         lvl_nxt = q_level - {1'b0, q_pop} + {1'b0, q_acc};
         if ((cmd_bad || (q_push && !q_acc)) && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
         busy_d = (state_d != S_IDLE) || (lvl_nxt != 2'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sr_q    <= 5'd0;
         bit_q   <= 3'd0;
         gap_q   <= 4'd0;
         ser_q   <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         drop_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         ser_q   <= ser_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.ser      = ser_q;
   assign bus.busy     = busy_q;
   assign bus.start    = start_q;
   assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_trigger_encoder.sv
// Random + directed bench for trigger_encoder, GAP=2 and GAP=0
// instances side by side against a line-schedule model.
module tb_trigger_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       sync;
   logic       trg;
   logic [2:0] code;
   bit         chk_en = 1'b0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   trigger_encoder_if b0 ();
   trigger_encoder_if b1 ();

   assign b0.sync    = sync;
   assign b0.trg_in  = trg;
   assign b0.data_in = code;
   assign b1.sync    = sync;
   assign b1.trg_in  = trg;
   assign b1.data_in = code;

   trigger_encoder #(.GAP(2)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0.slave)
   );

   trigger_encoder #(.GAP(0)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   // model: pending commands plus the bits still owed to the line
   int pat_v[6] = '{'h2, 'h6, 'hA, 'hE, 'h16, 'h1A};
   int pat_l[6] = '{2, 3, 4, 4, 5, 5};
   int gapv[2]  = '{2, 0};
   int mq[2][$];
   int ml[2][$];
   bit m_ser[2];
   bit m_busy[2];
   bit m_start[2];
   int m_drop[2];

   task automatic m_drop_inc(input int k);
      if (m_drop[k] < 255) m_drop[k]++;
   endtask

   task automatic m_load(input int k, input int c);
      for (int i = pat_l[c] - 1; i >= 0; i--)
         ml[k].push_back((pat_v[c] >> i) & 1);
      for (int i = 0; i < gapv[k]; i++)
         ml[k].push_back(0);
      m_ser[k]   = ml[k].pop_front() != 0;
      m_start[k] = 1'b1;
   endtask

   task automatic m_step(input int k);
      bit act;
      bit ok;
      int c;
      m_start[k] = 1'b0;
      if (reset) begin
         mq[k].delete();
         ml[k].delete();
         m_ser[k]  = 1'b0;
         m_busy[k] = 1'b0;
         m_drop[k] = 0;
         return;
      end
      if (!sync) return;
      ok  = trg && (code <= 3'd5);
      act = 1'b1;
      if (ml[k].size() > 0) begin
         m_ser[k] = ml[k].pop_front() != 0;
         if (ok) begin
            if (mq[k].size() < 2) mq[k].push_back(int'(code));
            else m_drop_inc(k);
         end
      end else if (mq[k].size() > 0) begin
         c = mq[k].pop_front();
         m_load(k, c);
         if (ok) mq[k].push_back(int'(code));
      end else if (ok) begin
         m_load(k, int'(code));
      end else begin
         m_ser[k] = 1'b0;
         act = 1'b0;
      end
      if (trg && code > 3'd5) m_drop_inc(k);
      m_busy[k] = act || (mq[k].size() > 0);
   endtask

   always @(posedge clk) begin
      m_step(0);
      m_step(1);
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ser0", 32'(b0.ser), 32'(m_ser[0]));
         check("busy0", 32'(b0.busy), 32'(m_busy[0]));
         check("start0", 32'(b0.start), 32'(m_start[0]));
         check("drop0", 32'(b0.drop_cnt), m_drop[0]);
         check("ser1", 32'(b1.ser), 32'(m_ser[1]));
         check("busy1", 32'(b1.busy), 32'(m_busy[1]));
         check("start1", 32'(b1.start), 32'(m_start[1]));
         check("drop1", 32'(b1.drop_cnt), m_drop[1]);
      end
   end

   task automatic cyc(input bit s, input bit t, input logic [2:0] c);
      sync = s;
      trg  = t;
      code = c;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1, 0, 0);
      reset = 1'b0;
   endtask

   logic [15:0] v;
   logic        acc;
   int          sp;

   initial begin
      reset = 1'b1;
      sync  = 1'b0;
      trg   = 1'b0;
      code  = 3'd0;
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk_en = 1'b1;
      check("rst_ser", 32'(b0.ser), 0);
      check("rst_busy", 32'(b0.busy), 0);
      check("rst_drop", 32'(b0.drop_cnt), 0);
      reset = 1'b0;
      cyc(1, 0, 0);

      // single TRIG, GAP=2
      cyc(1, 1, 0);
      check("trig_start", 32'(b0.start), 1);
      v = 16'(b0.ser);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0);
         v = {v[14:0], b0.ser};
      end
      check("trig_ser", 32'(v[3:0]), 4'b1000);
      check("trig_busy_e3", 32'(b0.busy), 1);
      cyc(1, 0, 0);
      check("trig_busy_e4", 32'(b0.busy), 0);

      // TOKEN then CAL back-to-back on the GAP=0 instance
      cyc(1, 1, 5);
      v = 16'(b1.ser);
      cyc(1, 1, 1);
      v = {v[14:0], b1.ser};
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0);
         v = {v[14:0], b1.ser};
      end
      check("tok_cal_ser", 32'(v[7:0]), 8'b11010110);
      for (int i = 0; i < 12; i++) cyc(1, 0, 0);

      // overflow: SYNC then four TRIGs
      do_reset();
      cyc(1, 1, 4);
      v = 16'(b1.ser);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 0);
         v = {v[14:0], b1.ser};
      end
      check("ovf_drop0", 32'(b0.drop_cnt), 2);
      check("ovf_drop1", 32'(b1.drop_cnt), 2);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0);
         v = {v[14:0], b1.ser};
      end
      check("ovf_ser1", 32'(v[8:0]), 9'b101101010);
      for (int i = 0; i < 16; i++) cyc(1, 0, 0);

      // invalid codes and saturation
      do_reset();
      cyc(1, 1, 7);
      check("inv_ser", 32'(b0.ser), 0);
      check("inv_busy", 32'(b0.busy), 0);
      check("inv_drop", 32'(b0.drop_cnt), 1);
      for (int i = 0; i < 300; i++) cyc(1, 1, 3'(6 + (i & 1)));
      check("sat_drop", 32'(b0.drop_cnt), 255);
      check("sat_drop1", 32'(b1.drop_cnt), 255);

      // sync one clk in four, RES_TBM
      do_reset();
      cyc(1, 1, 3);
      v = 16'(b0.ser);
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            cyc(0, 1, 7);
            v = {v[14:0], b0.ser};
            if (i == 0 && j == 0)
               check("gate_start_low", 32'(b0.start), 0);
         end
         cyc(1, 0, 0);
         v = {v[14:0], b0.ser};
      end
      for (int j = 0; j < 3; j++) begin
         cyc(0, 1, 7);
         v = {v[14:0], b0.ser};
      end
      check("gate_ser", 32'(v), 16'hFFF0);
      check("gate_drop", 32'(b0.drop_cnt), 0);
      for (int i = 0; i < 8; i++) cyc(1, 0, 0);

      // reset mid RES_ROC with one TRIG queued
      do_reset();
      cyc(1, 1, 2);
      cyc(1, 1, 0);
      cyc(1, 0, 0);
      check("mid_ser_pre", 32'(b0.ser), 1);
      reset = 1'b1;
      cyc(0, 0, 0);
      check("mid_ser_rst", 32'(b0.ser), 0);
      check("mid_busy_rst", 32'(b0.busy), 0);
      reset = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0, 0);
         acc = acc | b0.ser | b1.ser;
      end
      check("mid_quiet", 32'(acc), 0);

      // randomized traffic at varying sync density
      for (int i = 0; i < 4000; i++) begin
         sp    = (i / 800) % 3;
         reset = ($urandom_range(0, 299) == 0);
         sync  = (sp == 0) ? 1'b1 :
                 (sp == 1) ? ($urandom_range(0, 1) == 0) :
                             ($urandom_range(0, 3) == 0);
         trg   = ($urandom_range(0, 9) < 4);
         code  = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                             : 3'($urandom_range(0, 5));
         @(negedge clk);
      end
      reset = 1'b0;
      cyc(1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
